// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the 32-bit MIPS datapath: FETCH/DECODE/EXEC/MEM/WB with
// PC-write enable, data-memory ready handshake, sticky trap and retired-instruction counter.
module multicycle_control_fsm #(
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               Overflow,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               jump,
    output logic               beq,
    output logic               bne,
    output logic               mem_read,
    output logic               mem_write,
    output logic               alu_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write_en,
    output logic               jal_write_en,
    output logic [1:0]         alu_op,
    output logic [2:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [COUNT_W-1:0] instr_retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpSlti = 6'b001010;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpJal  = 6'b000011;

    // Value of the wait counter on the last tolerated not-ready MEM cycle.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e               r_state;
    logic [5:0]           r_opcode;
    logic [7:0]           r_wait;
    logic                 r_trap;
    logic [1:0]           r_cause;
    logic [COUNT_W-1:0]   r_retired;

    state_e               w_next_state;
    logic [1:0]           w_cause;
    logic                 w_legal;

    always_comb begin
        unique case (opcode)
            OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi,
            OpAndi, OpOri, OpSlti, OpJ, OpJal: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_cause      = 2'b00;
        pc_write     = 1'b0;
        jump         = 1'b0;
        beq          = 1'b0;
        bne          = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write_en = 1'b0;
        jal_write_en = 1'b0;
        alu_op       = 2'b00;

        case (r_state)
            StFetch: w_next_state = StDecode;
            StDecode: begin
                if (w_legal) begin
                    w_next_state = StExec;
                end else begin
                    w_next_state = StTrap;
                    w_cause      = 2'b01;
                end
            end
            StExec: begin
                w_next_state = StFetch;
                case (r_opcode)
                    OpR: begin
                        reg_dst      = 1'b1;
                        alu_op       = 2'b10;
                        w_next_state = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_src      = 1'b1;
                        w_next_state = StMem;
                    end
                    OpAddi: begin
                        alu_src      = 1'b1;
                        w_next_state = StWb;
                    end
                    OpAndi, OpOri, OpSlti: begin
                        alu_src      = 1'b1;
                        alu_op       = 2'b11;
                        w_next_state = StWb;
                    end
                    OpBeq: begin
                        beq      = 1'b1;
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                    end
                    OpBne: begin
                        bne      = 1'b1;
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                    end
                    OpJ: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                    OpJal: begin
                        jump         = 1'b1;
                        jal_write_en = 1'b1;
                        pc_write     = 1'b1;
                    end
                    default: w_next_state = StFetch;
                endcase
                if (Overflow && (r_opcode == OpR || r_opcode == OpAddi)) begin
                    w_next_state = StTrap;
                    w_cause      = 2'b10;
                end
            end
            StMem: begin
                alu_src   = 1'b1;
                mem_read  = (r_opcode == OpLw);
                mem_write = (r_opcode == OpSw);
                if (mem_ready) begin
                    if (r_opcode == OpLw) begin
                        w_next_state = StWb;
                    end else begin
                        pc_write     = 1'b1;
                        w_next_state = StFetch;
                    end
                end else if (r_wait == WaitLast) begin
                    w_next_state = StTrap;
                    w_cause      = 2'b11;
                end
            end
            StWb: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                w_next_state = StFetch;
                case (r_opcode)
                    OpLw: mem_to_reg = 1'b1;
                    OpR: begin
                        reg_dst = 1'b1;
                        alu_op  = 2'b10;
                    end
                    OpAddi: alu_src = 1'b1;
                    OpAndi, OpOri, OpSlti: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                    end
                    default: alu_op = 2'b00;
                endcase
            end
            StTrap: w_next_state = StTrap;
            default: w_next_state = StFetch;
        endcase

        // Strobes are forced quiet while reset is held, whatever the state register holds.
        if (reset) begin
            pc_write     = 1'b0;
            jump         = 1'b0;
            beq          = 1'b0;
            bne          = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            alu_src      = 1'b0;
            reg_dst      = 1'b0;
            mem_to_reg   = 1'b0;
            reg_write_en = 1'b0;
            jal_write_en = 1'b0;
            alu_op       = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StFetch;
            r_opcode  <= 6'b0;
            r_wait    <= 8'b0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == StDecode) begin
                r_opcode <= opcode;
            end
            if (r_state == StMem && w_next_state == StMem) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'b0;
            end
            if (w_next_state == StTrap && !r_trap) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
            if (pc_write) begin
                r_retired <= r_retired + COUNT_W'(1);
            end
        end
    end

    assign state         = r_state;
    assign trap          = r_trap;
    assign trap_cause    = r_cause;
    assign instr_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected state/strobes are queued as
// each cycle is driven and compared when the DUT presents its outputs on the falling edge.
module tb_multicycle_control_fsm;

    localparam int unsigned MemTimeout = 15;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // Strobe vector: {pc_write, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst,
    //                 mem_to_reg, reg_write_en, jal_write_en, alu_op[1:0]}
    localparam logic [12:0] S_PC  = 13'h1000;
    localparam logic [12:0] S_J   = 13'h0800;
    localparam logic [12:0] S_BEQ = 13'h0400;
    localparam logic [12:0] S_BNE = 13'h0200;
    localparam logic [12:0] S_MR  = 13'h0100;
    localparam logic [12:0] S_MW  = 13'h0080;
    localparam logic [12:0] S_AS  = 13'h0040;
    localparam logic [12:0] S_RD  = 13'h0020;
    localparam logic [12:0] S_M2R = 13'h0010;
    localparam logic [12:0] S_RW  = 13'h0008;
    localparam logic [12:0] S_JAL = 13'h0004;
    localparam logic [12:0] A_SUB = 13'h0001;
    localparam logic [12:0] A_RT  = 13'h0002;
    localparam logic [12:0] A_IMM = 13'h0003;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        Overflow;
    logic        mem_ready;
    logic        pc_write, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst;
    logic        mem_to_reg, reg_write_en, jal_write_en;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instr_retired;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_ret  = '0;
    logic        exp_trap = 1'b0;
    logic [1:0]  exp_cause = 2'b00;
    logic [12:0] obs_strb;

    assign obs_strb = {pc_write, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst,
                       mem_to_reg, reg_write_en, jal_write_en, alu_op};

    multicycle_control_fsm #(
        .COUNT_W     (32),
        .MEM_TIMEOUT (MemTimeout)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .Overflow      (Overflow),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .jump          (jump),
        .beq           (beq),
        .bne           (bne),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .alu_src       (alu_src),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write_en  (reg_write_en),
        .jal_write_en  (jal_write_en),
        .alu_op        (alu_op),
        .state         (state),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue the expectation, compare on the falling edge.
    task automatic step(input logic [2:0] st, input logic [12:0] strb,
                        input logic ovf, input logic rdy);
        exp_t e;
        Overflow  = ovf;
        mem_ready = rdy;
        e.st   = st;
        e.strb = strb;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq("state", {29'b0, state}, {29'b0, e.st});
        check_eq("strobes", {19'b0, obs_strb}, {19'b0, e.strb});
        check_eq("trap", {31'b0, trap}, {31'b0, exp_trap});
        check_eq("trap_cause", {30'b0, trap_cause}, {30'b0, exp_cause});
        check_eq("instr_retired", instr_retired, exp_ret);
        if (e.strb[12]) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] cur_st);
        reset = 1'b1;
        step(cur_st, 13'h0, 1'b0, 1'b0);
        exp_ret   = '0;
        exp_trap  = 1'b0;
        exp_cause = 2'b00;
        step(ST_FETCH, 13'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic enter_trap(input logic [1:0] cause);
        exp_trap  = 1'b1;
        exp_cause = cause;
        step(ST_TRAP, 13'h0, 1'b0, 1'b0);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Runs one instruction; mem_limit caps the MEM cycles driven (leaves the DUT in MEM).
    task automatic do_instr(input logic [5:0] op, input logic ovf, input int waits,
                            input int mem_limit);
        logic [12:0] ex;
        logic        rdy;
        logic        is_mem;
        opcode = op;
        step(ST_FETCH, 13'h0, 1'b0, 1'b0);
        step(ST_DECODE, 13'h0, 1'b0, 1'b0);
        if (!is_legal(op)) begin
            enter_trap(2'b01);
            return;
        end
        case (op)
            OP_R:                   ex = S_RD | A_RT;
            OP_LW, OP_SW, OP_ADDI:  ex = S_AS;
            OP_ANDI, OP_ORI, OP_SLTI: ex = S_AS | A_IMM;
            OP_BEQ:                 ex = S_BEQ | A_SUB | S_PC;
            OP_BNE:                 ex = S_BNE | A_SUB | S_PC;
            OP_J:                   ex = S_J | S_PC;
            default:                ex = S_J | S_JAL | S_PC;
        endcase
        step(ST_EXEC, ex, ovf, 1'b0);
        if (ex[12]) return;
        if (ovf && (op == OP_R || op == OP_ADDI)) begin
            enter_trap(2'b10);
            return;
        end
        is_mem = (op == OP_LW || op == OP_SW);
        if (is_mem) begin
            rdy = 1'b0;
            for (int i = 0; i < mem_limit; i++) begin
                rdy = (i >= waits);
                ex = S_AS | ((op == OP_LW) ? S_MR : S_MW) | ((op == OP_SW && rdy) ? S_PC : 13'h0);
                step(ST_MEM, ex, 1'b0, rdy);
                if (rdy) break;
                if (i + 1 == MemTimeout) begin
                    enter_trap(2'b11);
                    return;
                end
            end
            if (!rdy || op == OP_SW) return;
        end
        case (op)
            OP_LW:   ex = S_RW | S_PC | S_M2R;
            OP_R:    ex = S_RW | S_PC | S_RD | A_RT;
            OP_ADDI: ex = S_RW | S_PC | S_AS;
            default: ex = S_RW | S_PC | S_AS | A_IMM;
        endcase
        step(ST_WB, ex, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b0;
        Overflow  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(ST_FETCH);

        do_instr(OP_R, 1'b0, 0, 100);
        do_instr(OP_LW, 1'b0, 3, 100);
        do_instr(OP_SW, 1'b0, 0, 100);
        do_instr(OP_BEQ, 1'b0, 0, 100);
        do_instr(OP_JAL, 1'b0, 0, 100);
        do_instr(OP_BNE, 1'b0, 0, 100);
        do_instr(OP_J, 1'b0, 0, 100);
        do_instr(OP_ANDI, 1'b0, 0, 100);
        do_instr(OP_ORI, 1'b0, 0, 100);
        do_instr(OP_SLTI, 1'b1, 0, 100);
        do_instr(OP_ADDI, 1'b0, 0, 100);
        do_instr(OP_SW, 1'b0, 2, 100);
        do_instr(OP_LW, 1'b1, 0, 100);

        // Illegal opcode; TRAP must hold its cause against later stimulus.
        do_instr(6'b111111, 1'b0, 0, 100);
        opcode = OP_R;
        step(ST_TRAP, 13'h0, 1'b1, 1'b1);
        step(ST_TRAP, 13'h0, 1'b0, 1'b0);
        do_reset(ST_TRAP);

        do_instr(OP_ADDI, 1'b1, 0, 100);
        do_reset(ST_TRAP);

        do_instr(OP_R, 1'b1, 0, 100);
        do_reset(ST_TRAP);

        do_instr(OP_LW, 1'b0, 40, 100);
        step(ST_TRAP, 13'h0, 1'b0, 1'b1);
        do_reset(ST_TRAP);

        do_instr(OP_SW, 1'b0, 14, 100);

        // Reset in the middle of a stalled lw.
        do_instr(OP_LW, 1'b0, 40, 3);
        do_reset(ST_MEM);
        do_instr(OP_LW, 1'b0, 1, 100);

        check_eq("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
